picorv32_mem_slave: RTL and testbench

Synthesizable memory-side responder for the picorv32 native memory interface, sitting directly downstream of the core's `mem_*` port. It serves word-addressed on-chip RAM with byte strobes, a programmable number of wait states, and a small MMIO window with a console byte FIFO (valid/ready output), a status register and an optional free-running cycle counter. Unmapped accesses complete normally but return zero and raise a one-cycle bus-error pulse.

---
 rtl/picorv32_mem_slave_pkg.sv | 22 ++
 rtl/picorv32_mem_slave_if.sv | 20 ++
 rtl/picorv32_mem_slave_fifo.sv | 67 ++++++
 rtl/picorv32_mem_slave.sv | 163 ++++++++++++++++
 tb/tb_picorv32_mem_slave.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/picorv32_mem_slave_pkg.sv
// Shared types and MMIO map for the picorv32 memory-side responder.
// FSM encoding, console register offsets and status bit positions.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] CONS_DATA_OFS = 32'd0;
  localparam logic [31:0] CONS_STAT_OFS = 32'd4;
  localparam logic [31:0] CYCLE_OFS     = 32'd8;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;

  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/picorv32_mem_slave_if.sv
// picorv32 native memory bus: core drives the request, slave returns ready/rdata.
interface picorv32_mem_slave_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_mem_slave_fifo.sv
// Synchronous FIFO for the console byte stream; full/empty are registered flags.
module mem_slave_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_push_data,
  input  logic                         i_pop,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [DW-1:0]                o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_do_push;
  logic          w_do_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_do_push && w_do_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_head  = r_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/picorv32_mem_slave.sv
// picorv32 native-bus responder: byte-strobed RAM, wait states, console FIFO and MMIO status.
// Define MEMSLV_CYCLE_CNT_EN to build the free-running cycle counter at CONS_ADDR+8.
module picorv32_mem_slave
  import picorv32_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] CONS_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  picorv32_mem_slave_if.slave  bus,
  output logic                 cons_valid,
  output logic [7:0]           cons_data,
  input  logic                 cons_ready,
  output logic                 bus_err
);
  localparam int          RAM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          OCC_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [29:0] CDATA_W   = word_of(CONS_ADDR + CONS_DATA_OFS);
  localparam logic [29:0] CSTAT_W   = word_of(CONS_ADDR + CONS_STAT_OFS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [29:0]       r_word;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_instr;
  logic [31:0]       r_rdata;
  logic [31:0]       r_ram [MEM_WORDS];

  logic              w_is_ram;
  logic              w_is_cdata;
  logic              w_is_cstat;
  logic              w_is_cycle;
  logic              w_mapped;
  logic              w_is_write;
  logic              w_cons_push;
  logic              w_stall;
  logic              w_commit;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [31:0]       w_rd_val;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [OCC_W-1:0]  w_fifo_count;
  logic [7:0]        w_fifo_head;

  assign w_ram_idx  = r_word[RAM_AW-1:0];
  assign w_is_ram   = ({r_word, 2'b00} < RAM_BYTES);
  assign w_is_cdata = (r_word == CDATA_W);
  assign w_is_cstat = (r_word == CSTAT_W);
  assign w_mapped   = w_is_ram || w_is_cdata || w_is_cstat || w_is_cycle;
  // Fetches are reads regardless of strobes.
  assign w_is_write  = (r_wstrb != 4'b0000) && !r_instr;
  assign w_cons_push = w_is_cdata && w_is_write && r_wstrb[0];
  assign w_stall     = w_cons_push && w_fifo_full;
  assign w_commit    = (r_state == ST_RESP) && !reset;

`ifdef MEMSLV_CYCLE_CNT_EN
  localparam logic [29:0] CYCLE_W = word_of(CONS_ADDR + CYCLE_OFS);
  logic [31:0] r_cycle;

  always_ff @(posedge clk) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end

  assign w_is_cycle = (r_word == CYCLE_W);
`else
  assign w_is_cycle = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    if (w_is_ram) begin
      w_rd_val = r_ram[w_ram_idx];
    end else if (w_is_cdata) begin
      w_rd_val = 32'(w_fifo_count);
    end else if (w_is_cstat) begin
      w_rd_val[STAT_FULL]  = w_fifo_full;
      w_rd_val[STAT_EMPTY] = w_fifo_empty;
    end
`ifdef MEMSLV_CYCLE_CNT_EN
    else if (w_is_cycle) begin
      w_rd_val = r_cycle;
    end
`endif
  end

  // IDLE: wait for mem_valid | WAIT: count down, hold on console full | RESP: ready pulse, commit
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.mem_valid) w_state_nxt = ST_WAIT;
      ST_WAIT: if ((r_wait_cnt == 4'd0) && !w_stall) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_instr    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.mem_valid) begin
        r_word     <= bus.mem_addr[31:2];
        r_wdata    <= bus.mem_wdata;
        r_wstrb    <= bus.mem_wstrb;
        r_instr    <= bus.mem_instr;
        r_wait_cnt <= 4'(WAIT_STATES);
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      // Read data is captured on entry to RESP, so a RAM read sees the pre-write word.
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_RESP)) r_rdata <= w_rd_val;
      else                                                 r_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_is_ram && w_is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_ram[w_ram_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  mem_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_cons_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_commit && w_cons_push),
    .i_push_data (r_wdata[7:0]),
    .i_pop       (cons_ready),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_fifo_head)
  );

  assign bus.mem_ready = (r_state == ST_RESP);
  assign bus.mem_rdata = r_rdata;
  assign bus_err       = (r_state == ST_RESP) && !w_mapped;
  assign cons_valid    = !w_fifo_empty;
  assign cons_data     = w_fifo_head;

endmodule

// File: tb/tb_picorv32_mem_slave.sv
// Self-checking bench: two responders (WAIT_STATES 0 and 3) against a queue/array model.
// Honours MEMSLV_CYCLE_CNT_EN for the CONS_ADDR+8 expectations.
module tb_picorv32_mem_slave;
  import picorv32_mem_pkg::*;

  localparam logic [31:0] CONS   = 32'h1000_0000;
  localparam logic [29:0] CONS_W = 30'(CONS >> 2);
  localparam int          DEPTH  = 4;
  localparam int          WORDS  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        sel;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        cons_ready;

  int errors = 0;
  int checks = 0;

  picorv32_mem_slave_if bus0 ();
  picorv32_mem_slave_if bus1 ();

  assign bus0.mem_valid = valid & ~sel;
  assign bus1.mem_valid = valid & sel;
  assign bus0.mem_instr = instr;
  assign bus1.mem_instr = instr;
  assign bus0.mem_addr  = addr;
  assign bus1.mem_addr  = addr;
  assign bus0.mem_wdata = wdata;
  assign bus1.mem_wdata = wdata;
  assign bus0.mem_wstrb = wstrb;
  assign bus1.mem_wstrb = wstrb;

  logic       cv0, cv1, be0, be1;
  logic [7:0] cd0, cd1;

  picorv32_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .cons_valid(cv0), .cons_data(cd0), .cons_ready(cons_ready), .bus_err(be0));

  picorv32_mem_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .cons_valid(cv1), .cons_data(cd1), .cons_ready(cons_ready), .bus_err(be1));

  logic        rdy_s, err_s;
  logic [31:0] rd_s;
  assign rdy_s = sel ? bus1.mem_ready : bus0.mem_ready;
  assign err_s = sel ? be1 : be0;
  assign rd_s  = sel ? bus1.mem_rdata : bus0.mem_rdata;

  // Reference model
  logic [31:0] ram_m [2][WORDS];
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  function automatic int qsize(input logic s);
    return s ? q1.size() : q0.size();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: addr=%h got %h expected %h", name, addr, act, exp);
    end
  endtask

  task automatic model_access(input logic s, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd,
                              output logic er, output logic chk);
    logic [29:0] w;
    w = a[31:2];
    rd = '0; er = 1'b0; chk = (st == 4'b0000);
    if (a < 32'(WORDS * 4)) begin
      rd = ram_m[s][w[7:0]];
      for (int b = 0; b < 4; b++)
        if (st[b]) ram_m[s][w[7:0]][8*b +: 8] = wd[8*b +: 8];
    end else if (w == CONS_W) begin
      rd = 32'(qsize(s));
      if (st[0]) begin
        if (s) q1.push_back(wd[7:0]); else q0.push_back(wd[7:0]);
      end
    end else if (w == CONS_W + 30'd1) begin
      rd = {30'b0, qsize(s) == 0, qsize(s) == DEPTH};
    end
`ifdef MEMSLV_CYCLE_CNT_EN
    else if (w == CONS_W + 30'd2) begin
      chk = 1'b0;
    end
`endif
    else begin
      er = 1'b1;
    end
  endtask

  task automatic wait_ready(output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rdy_s) begin
        got = 1; rd = rd_s; er = err_s;
      end
    end
    valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ready_timeout: addr=%h no mem_ready within 200 cycles", addr);
    end else begin
      @(negedge clk);
      if (rdy_s !== 1'b0 || err_s !== 1'b0) begin
        errors++;
        $display("FAIL ready_pulse: addr=%h ready=%b bus_err=%b after completion, expected 0 0",
                 addr, rdy_s, err_s);
      end
    end
  endtask

  task automatic txn(input logic s, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic ins, output logic [31:0] rd,
                     output logic er, output int lat, output int acc);
    @(negedge clk);
    sel = s; addr = a; wdata = wd; wstrb = st; instr = ins; valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    wait_ready(rd, er, lat);
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic ins);
    logic [31:0] exp_rd, rd;
    logic        exp_er, er, chk;
    int          lat, acc;
    model_access(s, a, wd, st, exp_rd, exp_er, chk);
    txn(s, a, wd, st, ins, rd, er, lat, acc);
    check("latency", 32'(lat), s ? 32'd5 : 32'd2);
    check("bus_err", {31'b0, er}, {31'b0, exp_er});
    if (chk) check("rdata", rd, exp_rd);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd, r1, r2, dmy_rd;
    logic        er, dmy_er, dmy_chk;
    int          lat, acc1, acc2;
    bit          saw;

    tbl[0]  = '{1'b0, 32'h0000_03FC, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0010, 32'h0,         4'b0000, 32'h1122_33AA, 1'b0};
    tbl[5]  = '{1'b0, 32'h2000_0000, 32'h0,         4'b0000, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, CONS + 32'd4,  32'h0,         4'b0000, 32'h2,         1'b0};
    tbl[7]  = '{1'b0, CONS,          32'h0,         4'b0000, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, CONS + 32'd4,  32'h1234_5678, 4'b1111, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, CONS + 32'd4,  32'h0,         4'b0000, 32'h2,         1'b0};
    tbl[10] = '{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 32'h0,         1'b1};
    tbl[11] = '{1'b0, 32'h0000_03FE, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'b1111, 32'h0,         1'b0};
    tbl[13] = '{1'b1, 32'h0000_0020, 32'h0,         4'b0000, 32'h5555_5555, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_03FC, 32'h0000_7700, 4'b0010, 32'h0,         1'b0};
    tbl[15] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'hDEAD_77EF, 1'b0};

    reset = 1'b1; sel = 1'b0; valid = 1'b0; instr = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; cons_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready0", {31'b0, bus0.mem_ready}, 32'd0);
    check("rst_rdata0", bus0.mem_rdata, 32'd0);
    check("rst_err0",   {31'b0, be0}, 32'd0);
    check("rst_cvalid0", {31'b0, cv0}, 32'd0);
    check("rst_cdata0", {24'b0, cd0}, 32'd0);
    check("rst_ready1", {31'b0, bus1.mem_ready}, 32'd0);
    check("rst_rdata1", bus1.mem_rdata, 32'd0);
    check("rst_err1",   {31'b0, be1}, 32'd0);
    check("rst_cvalid1", {31'b0, cv1}, 32'd0);
    check("rst_cdata1", {24'b0, cd1}, 32'd0);
    reset = 1'b0;

    // Fill both RAMs so every later read has a defined expectation.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < WORDS; i++)
        do_op(s[0], 32'(i * 4), $urandom, 4'b1111, 1'b0);

    for (int i = 0; i < 16; i++) begin
      model_access(tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].st, dmy_rd, dmy_er, dmy_chk);
      txn(tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].st, 1'b0, rd, er, lat, acc1);
      check("vec_latency", 32'(lat), tbl[i].s ? 32'd5 : 32'd2);
      check("vec_bus_err", {31'b0, er}, {31'b0, tbl[i].exp_err});
      if (tbl[i].st == 4'b0000) check("vec_rdata", rd, tbl[i].exp_rd);
    end

    // Console full stall on the zero-wait responder.
    cons_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_op(1'b0, CONS, 32'h41 + 32'(i), 4'b0001, 1'b0);
    txn(1'b0, CONS, 32'h0, 4'b0000, 1'b0, rd, er, lat, acc1);
    check("occupancy_full", rd, 32'd4);
    txn(1'b0, CONS + 32'd4, 32'h0, 4'b0000, 1'b0, rd, er, lat, acc1);
    check("status_full", rd, 32'd1);
    @(negedge clk);
    sel = 1'b0; addr = CONS; wdata = 32'h45; wstrb = 4'b0001; instr = 1'b0; valid = 1'b1;
    @(posedge clk);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_s) saw = 1;
    end
    check("stall_hold", {31'b0, saw}, 32'd0);
    check("stall_head_valid", {31'b0, cv0}, 32'd1);
    check("stall_head_data", {24'b0, cd0}, 32'h41);
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
    check("stall_release_early", {31'b0, rdy_s}, 32'd0);
    void'(q0.pop_front());
    q0.push_back(8'h45);
    wait_ready(rd, er, lat);
    check("stall_release_lat", 32'(lat), 32'd1);
    check("stall_bus_err", {31'b0, er}, 32'd0);

    while (q0.size() > 0) begin
      check("drain_valid", {31'b0, cv0}, 32'd1);
      check("drain_data", {24'b0, cd0}, {24'b0, q0[0]});
      void'(q0.pop_front());
      cons_ready = 1'b1;
      @(negedge clk);
    end
    cons_ready = 1'b0;
    check("drain_empty", {31'b0, cv0}, 32'd0);
    check("drain_cdata", {24'b0, cd0}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic        s;
      int          k;
      logic [31:0] a;
      s = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 99));
      if (k < 60) begin
        a = 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1)
          do_op(s, a, 32'h0, 4'b0000, 1'($urandom_range(0, 1)));
        else
          do_op(s, a, $urandom, 4'($urandom_range(1, 15)), 1'b0);
      end else if (k < 72) begin
        case ($urandom_range(0, 3))
          0: a = 32'h400 + 32'd4 * 32'($urandom_range(0, 1000));
          1: a = CONS + 32'd12 + 32'd4 * 32'($urandom_range(0, 100));
          2: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
          default: a = CONS - 32'd4;
        endcase
        do_op(s, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      end else if (k < 86 || qsize(s) >= DEPTH) begin
        do_op(s, CONS + 32'd4 * 32'($urandom_range(0, 1)), 32'h0, 4'b0000, 1'b0);
      end else begin
        do_op(s, CONS, $urandom, 4'b0001, 1'b0);
      end
    end

`ifdef MEMSLV_CYCLE_CNT_EN
    txn(1'b0, CONS + 32'd8, 32'h0, 4'b0000, 1'b0, r1, er, lat, acc1);
    while (cyc < acc1 + 8) @(negedge clk);
    txn(1'b0, CONS + 32'd8, 32'h0, 4'b0000, 1'b0, r2, er, lat, acc2);
    check("cycle_delta", r2 - r1, 32'd10);
    check("cycle_bus_err", {31'b0, er}, 32'd0);
`else
    do_op(1'b0, CONS + 32'd8, 32'h0, 4'b0000, 1'b0);
    do_op(1'b1, CONS + 32'd8, 32'h0, 4'b0000, 1'b0);
    r1 = 32'h0; r2 = 32'h0; acc2 = 0;
`endif

    // Reset during WAIT of a RAM write on the 3-wait-state responder.
    @(negedge clk);
    sel = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; instr = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy_s) saw = 1;
    end
    check("reset_no_ready", {31'b0, saw}, 32'd0);
    check("reset_cvalid0", {31'b0, cv0}, 32'd0);
    do_op(1'b1, 32'h20, 32'h0, 4'b0000, 1'b0);
    txn(1'b1, 32'h20, 32'h0, 4'b0000, 1'b0, rd, er, lat, acc1);
    check("reset_ram_kept", rd, ram_m[1][8]);
    txn(1'b1, CONS + 32'd4, 32'h0, 4'b0000, 1'b0, rd, er, lat, acc1);
    check("reset_status1", rd, 32'd2);
    txn(1'b0, CONS + 32'd4, 32'h0, 4'b0000, 1'b0, rd, er, lat, acc1);
    check("reset_status0", rd, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
